// File: rtl/p_status.sv
// rtl/p_status.sv - 6502 processor status register with flag update priority
// and the one-instruction-delayed IRQ mask used by the interrupt sequencer.
module p_status #(
  parameter logic RESET_I = 1'b1,
  parameter logic RESET_D = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic       alu_en,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic [7:0] alu_y,
  input  logic       alu_a7,
  input  logic       alu_b7,
  input  logic       alu_sub,
  input  logic       alu_cout,
  input  logic       bit_en,
  input  logic [7:0] acc_in,
  input  logic [7:0] db_in,
  input  logic       plp_en,
  input  logic       flag_en,
  input  logic [2:0] flag_op,
  input  logic       int_en,
  input  logic       push_brk,
  output logic [7:0] p,
  output logic [7:0] p_push,
  output logic       carry,
  output logic       decen,
  output logic       irq_mask
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic irq_q, irq_d;
  logic pend_q, pend_d;
  logic pval_q, pval_d;
  logic cnt_q, cnt_d;
  logic flag_i_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      d_q    <= RESET_D;
      i_q    <= RESET_I;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      irq_q  <= RESET_I;
      pend_q <= 1'b0;
      pval_q <= 1'b0;
      cnt_q  <= 1'b0;
    end else begin
      n_q    <= n_d;
      v_q    <= v_d;
      d_q    <= d_d;
      i_q    <= i_d;
      z_q    <= z_d;
      c_q    <= c_d;
      irq_q  <= irq_d;
      pend_q <= pend_d;
      pval_q <= pval_d;
      cnt_q  <= cnt_d;
    end
  end

  // Sources applied lowest priority first so later ones override per flag.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    flag_i_wr = 1'b0;

    if (alu_en) begin
      if (upd_nz) begin
        n_d = alu_y[7];
        z_d = (alu_y == 8'h00);
      end
      if (upd_c) c_d = alu_cout;
      if (upd_v) v_d = (alu_a7 ^ alu_y[7]) & ~(alu_a7 ^ (alu_b7 ^ alu_sub));
    end

    if (bit_en) begin
      n_d = db_in[7];
      v_d = db_in[6];
      z_d = ((acc_in & db_in) == 8'h00);
    end

    if (flag_en) begin
      case (flag_op)
        3'd0: c_d = 1'b0;
        3'd1: c_d = 1'b1;
        3'd2: begin i_d = 1'b0; flag_i_wr = 1'b1; end
        3'd3: begin i_d = 1'b1; flag_i_wr = 1'b1; end
        3'd4: v_d = 1'b0;
        3'd5: d_d = 1'b0;
        3'd6: d_d = 1'b1;
        default: ;
      endcase
    end

    if (int_en) i_d = 1'b1;

    if (plp_en) begin
      n_d = db_in[7];
      v_d = db_in[6];
      d_d = db_in[3];
      i_d = db_in[2];
      z_d = db_in[1];
      c_d = db_in[0];
    end
  end

  // The pending I value reaches irq_mask on the second sync after the write.
  always_comb begin
    irq_d  = irq_q;
    pend_d = pend_q;
    pval_d = pval_q;
    cnt_d  = cnt_q;

    if (pend_q && sync) begin
      if (cnt_q) begin
        irq_d  = pval_q;
        pend_d = 1'b0;
      end else begin
        cnt_d = 1'b1;
      end
    end

    if (plp_en || (flag_i_wr && !int_en)) begin
      pend_d = 1'b1;
      pval_d = i_d;
      cnt_d  = 1'b0;
    end else if (int_en) begin
      irq_d  = 1'b1;
      pend_d = 1'b0;
      cnt_d  = 1'b0;
    end
  end

  assign p        = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign p_push   = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign carry    = c_q;
  assign decen    = d_q;
  assign irq_mask = irq_q;

endmodule

// File: doc/p_status.md
Name: p_status

Overview:
- Processor status register (P = N V 1 B D I Z C) for the 6502 core.
- Sits directly downstream of the adder/subtractor. It consumes the sum/difference, the carry-out and the operand sign bits, and computes N, V, Z and C.
- Feeds the carry-in and the decimal-enable signals back to the adder. Provides the pushed P byte for PHP, BRK and interrupt entry, and the IRQ mask for the interrupt sequencer.

Parameters:
- RESET_I, 1, value of the I flag after reset.
- RESET_D, 0, value of the D flag after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sync  in  1  opcode-fetch strobe; marks an instruction boundary.
- alu_en  in  1  ALU result valid this cycle; apply the upd_* masks.
- upd_nz  in  1  update N and Z from alu_y.
- upd_c  in  1  update C from alu_cout.
- upd_v  in  1  update V from the overflow computation.
- alu_y  in  8  adder result (after decimal correction).
- alu_a7  in  1  bit 7 of the adder input a.
- alu_b7  in  1  bit 7 of the adder input b (uninverted).
- alu_sub  in  1  adder add_sub select.
- alu_cout  in  1  adder carry_out.
- bit_en  in  1  BIT instruction: N<=db_in[7], V<=db_in[6], Z<=((acc_in & db_in)==0).
- acc_in  in  8  accumulator value.
- db_in  in  8  data bus; source for PLP/RTI and BIT.
- plp_en  in  1  load P from db_in (bits 5 and 4 ignored).
- flag_en  in  1  execute a flag instruction.
- flag_op  in  3  0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLV, 5 CLD, 6 SED, 7 no-op.
- int_en  in  1  interrupt/BRK entry; set I.
- push_brk  in  1  selects the B bit value in p_push.
- p  out  8  current P: {N,V,1,1,D,I,Z,C}.
- p_push  out  8  {N,V,1,push_brk,D,I,Z,C}; combinational.
- carry  out  1  C; drives the adder carry_in.
- decen  out  1  D; drives the adder decen.
- irq_mask  out  1  I as seen by the IRQ sampler (delayed, see below).

Behaviour:
- Reset (async):
  - C=Z=V=N=0, D=RESET_D, I=RESET_I, irq_mask=RESET_I.
  - p = 8'h34 with the defaults.
  - Reset mid-instruction discards every pending update, including a pending irq_mask change.
- Flags are registered. An update presented in cycle k is visible on p, carry and decen in cycle k+1.
- ALU update (alu_en=1):
  - N = alu_y[7].
  - Z = (alu_y == 0).
  - C = alu_cout.
  - V = (alu_a7 ^ alu_y[7]) & ~(alu_a7 ^ (alu_b7 ^ alu_sub)).
  - V uses the final (decimal-corrected) alu_y in decimal mode too. This is a decided simplification of NMOS behaviour.
  - Each flag group changes only when its upd_* bit is set.
- Per-flag priority when several sources hit the same flag in one cycle: plp_en > int_en (I only) > flag_en > bit_en > alu_en.
  - A lower-priority source may still update flags that a higher-priority source does not touch. Example: int_en with alu_en sets I and also updates NZ.
- plp_en loads N, V, D, I, Z, C from db_in bits 7, 6, 3, 2, 1, 0. Bits 5 and 4 are never stored.
- irq_mask pipeline:
  - A new I value becomes pending when written by CLI, SEI or PLP.
  - irq_mask takes the new I value on the second sync after the write. The instruction following the write still uses the old mask (6502 one-instruction latency).
  - A further I write before that transfer replaces the pending value and restarts the count.
  - int_en is the exception: it sets irq_mask to 1 in the same edge as I, with no delay, and cancels any pending value.
- Unused flag_op 7 leaves all flags unchanged.

Test Plan:
- Reset asserted mid-cycle with P=8'hFF loaded -> p=8'h34, carry=0, decen=0, irq_mask=1 immediately, without waiting for a clock edge.
- alu_en, all upd_* set, a7=0, b7=0, sub=0, alu_y=8'h80, cout=0 -> next cycle N=1, V=1, Z=0, C=0, p=8'hF4.
- alu_en, a7=1, b7=0, sub=1, alu_y=8'h00, cout=1, upd_v=0 -> Z=1, C=1, N=0, V unchanged.
- SED then CLC -> decen=1, carry=0.
- SED and plp_en with db_in=8'h00 in the same cycle -> D=0 (PLP wins).
- BIT with acc_in=8'h0F, db_in=8'hC0 -> N=1, V=1, Z=1, C unchanged.
- CLI at I=1, then sync, sync -> irq_mask still 1 after the first sync, 0 after the second.
- CLI pending, then int_en -> I=1 and irq_mask=1 next edge; the pending clear never applies.
- p_push with push_brk=0 after reset -> 8'h24; with push_brk=1 -> 8'h34.
